datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below, clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 s  in  1  start request; a new instruction is accepted when s=1 and w=1.
REQ-005 opcode  in  3  instruction opcode; sampled only at accept.
REQ-006 op  in  2  instruction sub-op; sampled only at accept.
REQ-007 w  out  1  idle/ready flag; 1 only in S_WAIT.
REQ-008 nsel  out  3  one-hot register-file select: 001=Rm, 010=Rd, 100=Rn, 000=none.
REQ-009 loada, loadb, loadc, loads  out  1 each  load enables for the A, B, C and status registers.
REQ-010 asel, bsel  out  1 each  asel=1 forces the ALU A operand to 0; bsel=1 selects the immediate operand for ALU B.
REQ-011 vsel  out  2  write-back source: 00=C register, 01=sign-extended imm8; 10 and 11 are reserved and never driven.
REQ-012 write  out  1  register-file write enable.
REQ-013 alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 not-B.
REQ-014 err  out  1  illegal-instruction flag; sticky until the next accept.

Function
REQ-015 FSM states SHALL be: S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_STATUS, S_WRITE_REG, S_WRITE_IMM.
REQ-016 On accept (S_WAIT, s=1), opcode and op SHALL be latched into internal registers, err SHALL clear, and the next state SHALL be S_DECODE.
- The latched values are used until return to S_WAIT.
- s and the opcode/op inputs are ignored in every other state.
REQ-017 From S_DECODE, the next state SHALL be chosen as follows:
- {110,10} MOV imm -> S_WRITE_IMM
- {110,00} MOV shifted reg -> S_GET_B
- {101,00/01/10} ADD/CMP/AND -> S_GET_A
- {101,11} MVN -> S_GET_B
- any other value -> S_WAIT with err=1
REQ-018 Remaining transitions SHALL be:
- S_GET_A -> S_GET_B
- S_GET_B -> S_STATUS if CMP, else S_EXEC
- S_EXEC -> S_WRITE_REG
- S_WRITE_REG, S_WRITE_IMM, S_STATUS -> S_WAIT
REQ-019 Outputs SHALL be Moore (decoded from state and latched instruction only). Any output not named for a state below is 0:
- S_WAIT: w=1.
- S_GET_A: nsel=100, loada=1.
- S_GET_B: nsel=001, loadb=1.
- S_EXEC: loadc=1; asel=1 for MOV shifted reg and MVN.
- S_STATUS: loads=1; alu_op=01.
- S_WRITE_REG: nsel=010, vsel=00, write=1.
- S_WRITE_IMM: nsel=100, vsel=01, write=1.
REQ-020 alu_op SHALL equal the latched op for opcode 101 and SHALL be 00 otherwise.
REQ-021 Accept-to-w latency SHALL be exactly: MOV imm 2 cycles; MOV reg 4; MVN 4; ADD/AND 5; CMP 4; illegal 2.
REQ-022 s held high continuously SHALL start a new instruction on every cycle where w=1. No extra idle cycle is inserted between instructions.
REQ-023 nsel SHALL be one-hot or zero in every state. write and loadc SHALL never be asserted in the same cycle.

Reset
REQ-024 rst_n=0 SHALL immediately force state to S_WAIT, latched opcode/op to 0 and err to 0, regardless of clk.
- Outputs: w=1, all other outputs 0.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction: no write, loads or loadc pulse after reset asserts.
REQ-026 After rst_n rises, the first accept SHALL occur no earlier than the first rising clk edge with s=1.

Structure
REQ-027 A shared package SHALL hold:
- the state enum type;
- opcode constants OPC_ALU=101 and OPC_MOV=110;
- nsel constants NSEL_RM, NSEL_RD, NSEL_RN;
- vsel constants VSEL_C and VSEL_IMM;
- alu_op constants.
REQ-028 The block SHALL be a single module with no sub-modules. Next-state logic, output decode and instruction latch each sit in their own always block.

Verification
REQ-029 Reset then MOV imm (s=1, opcode=110, op=10) -> next cycle S_DECODE; the cycle after, write=1, nsel=100, vsel=01; w=1 two cycles after accept.
REQ-030 ADD (101,00) -> loada with nsel=100, then loadb with nsel=001, then loadc with alu_op=00, then write with nsel=010; w returns 5 cycles after accept.
REQ-031 CMP (101,01) -> S_GET_A, S_GET_B, then loads=1 with alu_op=01; write stays 0 throughout; w returns after 4 cycles.
REQ-032 Illegal (111,00) -> err=1 and w=1 two cycles after accept; err clears on the next accept of MVN (101,11), which asserts loadc with asel=1 and alu_op=11.
REQ-033 Opcode/op changed to 110/10 during an ADD in progress -> ADD sequence unchanged.
REQ-034 rst_n pulsed low during S_EXEC of AND -> w=1 immediately; no write pulse follows.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath controller: FSM state type, opcode,
// register-select, write-back-source and ALU-operation encodings, plus the
// decode helper that maps a latched instruction to its first execute state.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_STATUS, S_WRITE_REG, S_WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [2:0] NSEL_NONE  = 3'b000;
  localparam logic [2:0] NSEL_RM    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RN    = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_NOTB   = 2'b11;

  // State entered from S_DECODE; S_WAIT means the instruction is illegal.
  function automatic state_t decode_next(input logic [2:0] opc, input logic [1:0] op);
    state_t nxt;
    nxt = S_WAIT;
    if (opc == OPC_MOV) begin
      if (op == OP_MOV_IMM)      nxt = S_WRITE_IMM;
      else if (op == OP_MOV_REG) nxt = S_GET_B;
    end else if (opc == OPC_ALU) begin
      nxt = (op == ALU_NOTB) ? S_GET_B : S_GET_A;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Instruction handshake and datapath control bundle.
//   s/opcode/op : instruction request (master -> controller)
//   w, err      : ready and illegal-instruction status
//   nsel, load*, asel, bsel, vsel, write, alu_op : datapath controls
interface datapath_ctrl_if;
  import datapath_ctrl_pkg::*;

  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       write;
  logic [1:0] alu_op;
  logic       err;

  modport master (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, err
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, err
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle datapath controller. Accepts an instruction when idle (w=1,s=1),
// latches opcode/op, then sequences register reads, ALU execute, status update
// or register write-back. Outputs are decoded from state and the latched
// instruction only.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (returns to idle, abandons instruction)
//   bus   : slave side of datapath_ctrl_if (request in, controls/status out)
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  datapath_ctrl_if.slave bus
);

  state_t     r_state, w_next;
  logic [2:0] r_opcode;
  logic [1:0] r_op;
  logic       r_err;
  logic       w_accept;
  logic       w_is_cmp;

  assign w_accept = (r_state == S_WAIT) && bus.s;
  assign w_is_cmp = (r_opcode == OPC_ALU) && (r_op == ALU_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:      if (bus.s) w_next = S_DECODE;
      S_DECODE:    w_next = decode_next(r_opcode, r_op);
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = w_is_cmp ? S_STATUS : S_EXEC;
      S_EXEC:      w_next = S_WRITE_REG;
      S_STATUS,
      S_WRITE_REG,
      S_WRITE_IMM: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Instruction latch and sticky error: err is raised when decode bounces an
  // illegal instruction back to idle, and only a new accept clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_op     <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_opcode <= bus.opcode;
      r_op     <= bus.op;
      r_err    <= 1'b0;
    end else if (r_state == S_DECODE && w_next == S_WAIT) begin
      r_err    <= 1'b1;
    end
  end

  always_comb begin
    bus.w      = 1'b0;
    bus.nsel   = NSEL_NONE;
    bus.loada  = 1'b0;
    bus.loadb  = 1'b0;
    bus.loadc  = 1'b0;
    bus.loads  = 1'b0;
    bus.asel   = 1'b0;
    bus.bsel   = 1'b0;
    bus.vsel   = VSEL_C;
    bus.write  = 1'b0;
    bus.err    = r_err;
    bus.alu_op = (r_opcode == OPC_ALU) ? r_op : ALU_ADD;
    case (r_state)
      S_WAIT:      bus.w = 1'b1;
      S_GET_A:     begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GET_B:     begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      // Only MOV-reg and MVN use asel here: both pass B through with A zeroed.
      S_EXEC:      begin
                     bus.loadc = 1'b1;
                     bus.asel  = (r_opcode == OPC_MOV) || (r_op == ALU_NOTB);
                   end
      S_STATUS:    begin bus.loads = 1'b1; bus.alu_op = ALU_SUB; end
      S_WRITE_REG: begin bus.nsel = NSEL_RD; bus.vsel = VSEL_C; bus.write = 1'b1; end
      S_WRITE_IMM: begin bus.nsel = NSEL_RN; bus.vsel = VSEL_IMM; bus.write = 1'b1; end
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: directed instruction scenarios with
// literal expectations, then randomized request traffic compared every cycle
// against an instruction-recipe model (a queue of expected control steps).
module tb_datapath_ctrl;

  typedef struct packed {
    logic [2:0] nsel;
    logic       la, lb, lc, ls, as;
    logic [1:0] vs;
    logic       wr;
    logic [1:0] alu;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  exp_t m_q[$];
  logic m_err = 1'b0;
  logic m_pend = 1'b0;

  datapath_ctrl_if bus();

  datapath_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] ns, input logic la, lb, lc, ls, as,
                              input logic [1:0] vs, input logic wr, input logic [1:0] alu);
    exp_t e;
    e = '{nsel: ns, la: la, lb: lb, lc: lc, ls: ls, as: as, vs: vs, wr: wr, alu: alu};
    return e;
  endfunction

  // Each instruction expands to the list of control steps it must produce,
  // one per cycle, starting with the silent decode cycle.
  task automatic push_sched(input logic [2:0] opc, input logic [1:0] op);
    exp_t z, ga, gb, wrr;
    z   = '0;
    ga  = mk(3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    gb  = mk(3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00);
    wrr = mk(3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00);
    m_pend = 1'b0;
    if (opc == 3'b110 && op == 2'b10) begin
      m_q.push_back(z); m_q.push_back(mk(3'b100, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00));
    end else if (opc == 3'b110 && op == 2'b00) begin
      m_q.push_back(z); m_q.push_back(gb);
      m_q.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00)); m_q.push_back(wrr);
    end else if (opc == 3'b101 && op == 2'b01) begin
      m_q.push_back(z); m_q.push_back(ga); m_q.push_back(gb);
      m_q.push_back(mk(3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 2'b01));
    end else if (opc == 3'b101 && op == 2'b11) begin
      m_q.push_back(z); m_q.push_back(gb);
      m_q.push_back(mk(3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 2'b11)); m_q.push_back(wrr);
    end else if (opc == 3'b101) begin
      m_q.push_back(z); m_q.push_back(ga); m_q.push_back(gb);
      m_q.push_back(mk(3'b000, 0, 0, 1, 0, 0, 2'b00, 0, op)); m_q.push_back(wrr);
    end else begin
      m_q.push_back(z);
      m_pend = 1'b1;
    end
  endtask

  // Model advance: idle + s accepts a new recipe; otherwise consume one step.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete(); m_err = 1'b0; m_pend = 1'b0;
      end else if (m_q.size() == 0) begin
        if (bus.s) begin m_err = 1'b0; push_sched(bus.opcode, bus.op); end
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0 && m_pend) begin m_err = 1'b1; m_pend = 1'b0; end
      end
    end
  end

  // Per-cycle comparison; alu_op is only meaningful on loadc/loads cycles.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e = (m_q.size() != 0) ? m_q[0] : exp_t'('0);
        a = mk(bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
               bus.vsel, bus.write, (e.lc | e.ls) ? bus.alu_op : 2'b00);
        chk("cyc_w",    {31'd0, bus.w}, {31'd0, m_q.size() == 0});
        chk("cyc_err",  {31'd0, bus.err}, {31'd0, m_err});
        chk("cyc_ctl",  {16'd0, a}, {16'd0, e});
        chk("cyc_bsel", {31'd0, bus.bsel}, 32'd0);
      end
    end
  end

  task automatic run_instr(input logic [2:0] opc, input logic [1:0] op, output int lat,
                           output logic err1, output logic lc_as, output logic [1:0] lc_alu);
    bus.s = 1'b1; bus.opcode = opc; bus.op = op;
    @(posedge clk); #1;
    bus.s = 1'b0; bus.opcode = 3'b110; bus.op = 2'b10;  // must not disturb the latched instruction
    err1 = bus.err; lc_as = 1'bx; lc_alu = 2'bxx; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bus.loadc) begin lc_as = bus.asel; lc_alu = bus.alu_op; end
    end while (!bus.w && lat < 20);
  endtask

  initial begin
    int lat;
    logic e1, las;
    logic [1:0] lal;
    bit saw_wr;
    rst_n = 1'b0; bus.s = 1'b0; bus.opcode = '0; bus.op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w",    {31'd0, bus.w}, 32'd1);
    chk("rst_nsel", {29'd0, bus.nsel}, 32'd0);
    chk("rst_ctl",  {27'd0, bus.write, bus.loadc, bus.loads, bus.loada, bus.loadb}, 32'd0);
    chk("rst_err",  {31'd0, bus.err}, 32'd0);
    rst_n = 1'b1; cmp_en = 1'b1;
    @(posedge clk); #1;

    // MOV imm
    bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
    @(posedge clk); #1;
    bus.s = 1'b0;
    chk("movi_dec_w", {31'd0, bus.w}, 32'd0);
    chk("movi_dec_wr", {31'd0, bus.write}, 32'd0);
    @(posedge clk); #1;
    chk("movi_wr",   {31'd0, bus.write}, 32'd1);
    chk("movi_nsel", {29'd0, bus.nsel}, 32'h4);
    chk("movi_vsel", {30'd0, bus.vsel}, 32'h1);
    @(posedge clk); #1;
    chk("movi_w", {31'd0, bus.w}, 32'd1);

    run_instr(3'b101, 2'b00, lat, e1, las, lal);
    chk("add_lat", lat, 32'd5);
    chk("add_alu", {30'd0, lal}, 32'd0);
    run_instr(3'b101, 2'b01, lat, e1, las, lal);
    chk("cmp_lat", lat, 32'd4);
    run_instr(3'b110, 2'b00, lat, e1, las, lal);
    chk("movr_lat", lat, 32'd4);
    chk("movr_asel", {31'd0, las}, 32'd1);
    run_instr(3'b101, 2'b10, lat, e1, las, lal);
    chk("and_lat", lat, 32'd5);
    chk("and_alu", {30'd0, lal}, 32'h2);

    // Illegal: err and w both up two cycles after accept
    bus.s = 1'b1; bus.opcode = 3'b111; bus.op = 2'b00;
    @(posedge clk); #1;
    bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ill_err", {31'd0, bus.err}, 32'd1);
    chk("ill_w",   {31'd0, bus.w}, 32'd1);

    run_instr(3'b101, 2'b11, lat, e1, las, lal);
    chk("mvn_errclr", {31'd0, e1}, 32'd0);
    chk("mvn_lat",  lat, 32'd4);
    chk("mvn_asel", {31'd0, las}, 32'd1);
    chk("mvn_alu",  {30'd0, lal}, 32'h3);

    // Reset during S_EXEC of AND
    bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b10;
    @(posedge clk); #1;
    bus.s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rx_loadc", {31'd0, bus.loadc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rx_w",     {31'd0, bus.w}, 32'd1);
    chk("rx_loadc0", {31'd0, bus.loadc}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_wr = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.write) saw_wr = 1'b1;
    end
    chk("rx_nowrite", {31'd0, saw_wr}, 32'd0);

    // Random traffic, including back-to-back accepts with s held high
    repeat (600) begin
      int r;
      @(posedge clk); #1;
      bus.s = ($urandom % 4) != 0;
      r = $urandom % 4;
      bus.opcode = (r == 0) ? 3'b101 : (r == 1) ? 3'b110 : 3'($urandom % 8);
      bus.op = 2'($urandom % 4);
    end
    bus.s = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
